// File: rtl/fcl_sqrt_arb_pkg.sv
// Shared definitions for the FCL sqrt-core arbiter: state encoding,
// width helper and the default watchdog depth.
package fcl_sqrt_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   // Bits needed to index 0..value-1 (at least one bit).
   function automatic int clogb2(input int value);
      int v;
      int res;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >>> 1;
      end
      if (res == 0) begin
         res = 1;
      end else begin
         res = res;
      end
      return res;
   endfunction

endpackage

// File: rtl/fcl_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo N.
module fcl_rr_pick
   import fcl_sqrt_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_idx,
   output logic           o_any
);

   // Scan farthest-to-nearest so the slot closest to the pointer wins last.
   always_comb begin
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(i_ptr) + k;
         if (j >= N) begin
            j = j - N;
         end else begin
            j = j;
         end
         if (i_req[j]) begin
            o_grant    = '0;
            o_grant[j] = 1'b1;
            o_idx      = IDW'(j);
            o_any      = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/fcl_sqrt_arbiter.sv
// Round-robin front end sharing one iterative sqrt core between NUM_REQ
// lanes: arbitrate, issue, wait with watchdog, return result.
module fcl_sqrt_arbiter
   import fcl_sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH_IN  = 32,
   parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN / 2,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                              clk_in,
   input  logic                              _reset_in,
   input  logic [NUM_REQ-1:0]                req_valid_in,
   output logic [NUM_REQ-1:0]                req_ready_out,
   input  logic [NUM_REQ*DATA_WIDTH_IN-1:0]  req_data_in,
   output logic [NUM_REQ-1:0]                resp_valid_out,
   input  logic [NUM_REQ-1:0]                resp_ready_in,
   output logic [DATA_WIDTH_OUT-1:0]         resp_data_out,
   output logic                              resp_err_out,
   output logic                              sqrt_start_out,
   output logic [DATA_WIDTH_IN-1:0]          sqrt_data_out,
   input  logic                              sqrt_done_in,
   input  logic [DATA_WIDTH_OUT-1:0]         sqrt_result_in,
   output logic                              busy_out,
   output logic                              timeout_err_out
);

   localparam int ID_WIDTH = clogb2(NUM_REQ);
   localparam int WD_WIDTH = clogb2(TIMEOUT_CYCLES + 1);

   logic [1:0]                r_state;
   logic [ID_WIDTH-1:0]       r_ptr;
   logic [ID_WIDTH-1:0]       r_grant;
   logic [DATA_WIDTH_IN-1:0]  r_operand;
   logic [DATA_WIDTH_OUT-1:0] r_result;
   logic                      r_err;
   logic                      r_start;
   logic                      r_timeout;
   logic [NUM_REQ-1:0]        r_resp_valid;
   logic [WD_WIDTH-1:0]       r_wdog;

   logic [NUM_REQ-1:0]        w_grant;
   logic [ID_WIDTH-1:0]       w_idx;
   logic                      w_any;
   logic [NUM_REQ-1:0]        w_grant_oh;
   logic [ID_WIDTH-1:0]       w_next_ptr;

   fcl_rr_pick #(
      .N   (NUM_REQ),
      .IDW (ID_WIDTH)
   ) u_pick (
      .i_req   (req_valid_in),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
   assign w_next_ptr = (r_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant + ID_WIDTH'(1);

   assign req_ready_out   = (r_state == ST_IDLE) ? w_grant : '0;
   assign resp_valid_out  = r_resp_valid;
   assign resp_data_out   = r_result;
   assign resp_err_out    = r_err;
   assign sqrt_start_out  = r_start;
   assign sqrt_data_out   = r_operand;
   assign busy_out        = (r_state != ST_IDLE);
   assign timeout_err_out = r_timeout;

   // Operation sequencer; the ISSUE cycle counts as the first watchdog cycle,
   // so expiry lands exactly TIMEOUT_CYCLES after the start pulse.
   always_ff @(posedge clk_in or negedge _reset_in) begin
      if (!_reset_in) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_grant      <= '0;
         r_operand    <= '0;
         r_result     <= '0;
         r_err        <= 1'b0;
         r_start      <= 1'b0;
         r_timeout    <= 1'b0;
         r_resp_valid <= '0;
         r_wdog       <= '0;
      end else begin
         r_start   <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_operand <= req_data_in[w_idx*DATA_WIDTH_IN +: DATA_WIDTH_IN];
                  r_grant   <= w_idx;
                  r_start   <= 1'b1;
                  r_state   <= ST_ISSUE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               r_wdog  <= WD_WIDTH'(TIMEOUT_CYCLES - 1);
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (sqrt_done_in) begin
                  r_result     <= sqrt_result_in;
                  r_err        <= 1'b0;
                  r_resp_valid <= w_grant_oh;
                  r_state      <= ST_RESP;
               end else if (r_wdog == WD_WIDTH'(1)) begin
                  r_wdog       <= '0;
                  r_timeout    <= 1'b1;
                  r_result     <= '0;
                  r_err        <= 1'b1;
                  r_resp_valid <= w_grant_oh;
                  r_state      <= ST_RESP;
               end else begin
                  r_wdog <= r_wdog - WD_WIDTH'(1);
               end
            end
            ST_RESP: begin
               if (resp_ready_in[r_grant]) begin
                  r_resp_valid <= '0;
                  r_ptr        <= w_next_ptr;
                  r_state      <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fcl_sqrt_arbiter.sv
// Directed bench for fcl_sqrt_arbiter with a behavioural 5-cycle sqrt core
// and an injector for stray/forced done pulses.
module tb_fcl_sqrt_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int OW = 16;
   localparam int TO = 64;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [OW-1:0]   resp_data;
   logic            resp_err;
   logic            sqrt_start;
   logic [DW-1:0]   sqrt_data;
   logic            sqrt_done;
   logic [OW-1:0]   sqrt_result;
   logic            busy;
   logic            tmo;

   logic            core_en;
   logic [3:0]      core_cnt;
   logic            core_done;
   logic [OW-1:0]   core_res;
   logic            inj_done;
   logic [OW-1:0]   inj_res;

   int checks;
   int failures;
   int start_cnt;

   fcl_sqrt_arbiter #(
      .NUM_REQ        (N),
      .DATA_WIDTH_IN  (DW),
      .DATA_WIDTH_OUT (OW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_in          (clk),
      ._reset_in       (rst_n),
      .req_valid_in    (req_valid),
      .req_ready_out   (req_ready),
      .req_data_in     (req_data),
      .resp_valid_out  (resp_valid),
      .resp_ready_in   (resp_ready),
      .resp_data_out   (resp_data),
      .resp_err_out    (resp_err),
      .sqrt_start_out  (sqrt_start),
      .sqrt_data_out   (sqrt_data),
      .sqrt_done_in    (sqrt_done),
      .sqrt_result_in  (sqrt_result),
      .busy_out        (busy),
      .timeout_err_out (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [OW-1:0] isqrt(input logic [DW-1:0] x);
      logic [63:0] r;
      logic [63:0] t;
      r = 64'd0;
      for (int b = OW - 1; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= {32'd0, x}) r = t;
      end
      return r[OW-1:0];
   endfunction

   // Behavioural core: done pulse five cycles after the start pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_cnt  <= 4'd0;
         core_done <= 1'b0;
         core_res  <= '0;
      end else begin
         core_done <= 1'b0;
         if (sqrt_start && core_en) begin
            core_cnt <= 4'd4;
            core_res <= isqrt(sqrt_data);
         end else if (core_cnt != 4'd0) begin
            core_cnt <= core_cnt - 4'd1;
            if (core_cnt == 4'd1) core_done <= 1'b1;
         end
      end
   end

   assign sqrt_done   = core_done | inj_done;
   assign sqrt_result = core_done ? core_res : inj_res;

   always @(posedge clk) begin
      if (rst_n && sqrt_start) start_cnt <= start_cnt + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks = checks + 1;
         assert (((req_ready != '0) && (resp_valid != '0)) === 1'b0) else begin
            failures = failures + 1;
            $error("FAIL ready_valid_excl observed ready=%0h valid=%0h required one of them 0", req_ready, resp_valid);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_resp;
      int n;
      n = 0;
      while (resp_valid == '0 && n < 100) begin
         tick;
         n++;
      end
      chk("resp_wait", {63'd0, resp_valid != '0}, 64'd1);
   endtask

   task automatic handshake(input logic [N-1:0] who);
      resp_ready = who;
      tick;
      resp_ready = '0;
      chk("resp_clear", {60'd0, resp_valid}, 64'd0);
   endtask

   logic [OW-1:0] exp_res [N];
   logic [DW-1:0] ops     [N];
   int            cnt;

   initial begin
      checks = 0; failures = 0; start_cnt = 0;
      rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = '0;
      core_en = 1'b1; inj_done = 1'b0; inj_res = '0;
      ops     = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'd1000000};
      exp_res = '{16'd0, 16'd1, 16'd65535, 16'd1000};

      repeat (3) tick;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
      chk("rst_start", {63'd0, sqrt_start}, 64'd0);
      chk("rst_data", {32'd0, sqrt_data}, 64'd0);
      chk("rst_tmo", {63'd0, tmo}, 64'd0);
      rst_n = 1'b1;
      tick;

      // Single requester 1, operand 144
      req_valid = 4'b0010; req_data[1*DW +: DW] = 32'd144;
      #1 chk("t1_ready", {60'd0, req_ready}, 64'h2);
      tick;
      req_valid = '0;
      chk("t1_start", {63'd0, sqrt_start}, 64'd1);
      chk("t1_sqdata", {32'd0, sqrt_data}, 64'd144);
      tick;
      chk("t1_start_once", {63'd0, sqrt_start}, 64'd0);
      wait_resp;
      chk("t1_valid", {60'd0, resp_valid}, 64'h2);
      chk("t1_data", {48'd0, resp_data}, 64'd12);
      chk("t1_err", {63'd0, resp_err}, 64'd0);
      chk("t1_starts", 64'(start_cnt), 64'd1);
      handshake(4'b0010);
      chk("t1_idle", {63'd0, busy}, 64'd0);

      // Reset pointer, then all four continuously valid
      rst_n = 1'b0; tick; rst_n = 1'b1; tick;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ops[i];
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         #1 chk("t2_ready", {60'd0, req_ready}, 64'd1 << i);
         tick;
         wait_resp;
         chk("t2_valid", {60'd0, resp_valid}, 64'd1 << i);
         chk("t2_data", {48'd0, resp_data}, {48'd0, exp_res[i]});
         chk("t2_err", {63'd0, resp_err}, 64'd0);
         resp_ready = 4'(1 << i);
         tick;
         resp_ready = '0;
         if (i == N - 1) req_valid = '0;
      end

      // Requester 2 stalls the response for 10 cycles
      req_valid = 4'b0100; req_data[2*DW +: DW] = 32'd49;
      #1 chk("t3_ready", {60'd0, req_ready}, 64'h4);
      tick;
      req_valid = 4'b1011; resp_ready = 4'b1011;
      wait_resp;
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_valid", {60'd0, resp_valid}, 64'h4);
         chk("t3_hold_data", {48'd0, resp_data}, 64'd7);
         chk("t3_hold_ready", {60'd0, req_ready}, 64'd0);
         tick;
      end
      chk("t3_starts", 64'(start_cnt), 64'd6);
      req_valid = '0;
      handshake(4'b0100);

      // Core never answers: watchdog
      core_en = 1'b0;
      req_valid = 4'b1000; req_data[3*DW +: DW] = 32'd25;
      tick;
      req_valid = '0;
      chk("t4_start", {63'd0, sqrt_start}, 64'd1);
      cnt = 0;
      while (!tmo && cnt < 200) begin
         tick;
         cnt++;
      end
      chk("t4_tmo_delay", 64'(cnt), 64'd64);
      chk("t4_valid", {60'd0, resp_valid}, 64'h8);
      chk("t4_err", {63'd0, resp_err}, 64'd1);
      chk("t4_data", {48'd0, resp_data}, 64'd0);
      tick;
      chk("t4_tmo_pulse", {63'd0, tmo}, 64'd0);
      handshake(4'b1000);
      chk("t4_idle", {63'd0, busy}, 64'd0);
      core_en = 1'b1;

      // Reset during WAIT, then a late done
      req_valid = 4'b0001; req_data[0 +: DW] = 32'd400;
      tick;
      req_valid = '0;
      tick; tick;
      chk("t5_busy_pre", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", {63'd0, busy}, 64'd0);
      chk("t5_rst_sqdata", {32'd0, sqrt_data}, 64'd0);
      chk("t5_rst_valid", {60'd0, resp_valid}, 64'd0);
      chk("t5_rst_err", {63'd0, resp_err}, 64'd0);
      tick; tick;
      rst_n = 1'b1;
      inj_done = 1'b1; inj_res = 16'd20;
      tick;
      inj_done = 1'b0;
      tick;
      chk("t5_late_done_busy", {63'd0, busy}, 64'd0);
      chk("t5_late_done_valid", {60'd0, resp_valid}, 64'd0);
      req_valid = 4'b0010; req_data[1*DW +: DW] = 32'd81;
      #1 chk("t5_ready", {60'd0, req_ready}, 64'h2);
      tick;
      req_valid = '0;
      wait_resp;
      chk("t5_valid", {60'd0, resp_valid}, 64'h2);
      chk("t5_data", {48'd0, resp_data}, 64'd9);
      chk("t5_err", {63'd0, resp_err}, 64'd0);
      inj_done = 1'b1; inj_res = 16'h0077;
      tick;
      inj_done = 1'b0;
      chk("t6_resp_spur_data", {48'd0, resp_data}, 64'd9);
      chk("t6_resp_spur_valid", {60'd0, resp_valid}, 64'h2);
      handshake(4'b0010);

      // Done coinciding with watchdog expiry
      core_en = 1'b0;
      req_valid = 4'b0100; req_data[2*DW +: DW] = 32'd16;
      tick;
      req_valid = '0;
      chk("t6_start", {63'd0, sqrt_start}, 64'd1);
      repeat (TO - 1) tick;
      inj_done = 1'b1; inj_res = 16'h1234;
      tick;
      inj_done = 1'b0;
      chk("t6_coinc_valid", {60'd0, resp_valid}, 64'h4);
      chk("t6_coinc_data", {48'd0, resp_data}, 64'h1234);
      chk("t6_coinc_err", {63'd0, resp_err}, 64'd0);
      chk("t6_coinc_tmo", {63'd0, tmo}, 64'd0);
      tick;
      chk("t6_coinc_tmo2", {63'd0, tmo}, 64'd0);
      handshake(4'b0100);
      chk("t6_idle", {63'd0, busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
